prefix_addsub_pipe: RTL and testbench
=====================================

# prefix_addsub_pipe

Parametrised, pipelined Kogge-Stone prefix adder/subtractor that generalises the team's fixed 16-bit combinational prefix adder to any power-of-two width. Each prefix level is registered, giving one result per cycle at high clock rates, with valid/ready flow control, a sideband tag and arithmetic status flags. It sits in the datapath between operand-issue logic and the writeback/flag stage.

## Interface
- `WIDTH`, 16: operand width. Power of two, at least 4. `LEVELS` = log2(`WIDTH`) prefix levels.
- `TAG_W`, 4: width of the sideband tag carried alongside each operation (at least 1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: block can accept an operation this cycle.
- `a` in `WIDTH`: operand A.
- `b` in `WIDTH`: operand B.
- `cin` in 1: carry-in. Used only when `sub`=0.
- `sub` in 1: 1 computes a−b; 0 computes a+b+cin.
- `tag_in` in `TAG_W`: sideband tag, returned unchanged with the result.
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts the result.
- `sum` out `WIDTH`: result, modulo 2^`WIDTH`.
- `cout` out 1: carry out of the MSB. For subtraction, 1 means no borrow (a ≥ b unsigned).
- `ovf` out 1: two's-complement signed overflow.
- `zero` out 1: `sum` is all zeros.
- `tag_out` out `TAG_W`: tag of the current result.

## Operation
- **Stage 0 (capture).** On accept (`in_valid && in_ready`):
  - b' = `sub` ? ~`b` : `b`.
  - c0 = `sub` ? 1 : `cin`.
  - Register p = a^b', g = a&b', c0, `tag_in`, and the MSBs a[W-1] and b'[W-1].
- **Stages 1..LEVELS (prefix).** Level k uses distance d = 2^(k-1).
  - For i ≥ d: G_i = G_i | (P_i & G_(i-d)); P_i = P_i & P_(i-d).
  - For i < d: the pair passes through unchanged.
  - Bit-level p, c0, the tag and the MSB bits travel alongside, registered at every level.
- **Carry-in.** The carry-in is folded in before level 1 as G_0 = g_0 | (p_0 & c0). It must not be applied a second time at the output.
- **Output (combinational from the last register).**
  - c_0 = c0; c_(i+1) = G_i, the final group generate.
  - `sum`[i] = p_i ^ c_i.
  - `cout` = c_W.
  - `ovf` = c_W ^ c_(W-1).
  - `zero` = ~|`sum`.
  - `tag_out` = registered tag.
- **Flow control.** One global advance enable: adv = ~`out_valid` | `out_ready`.
  - When adv=1, every stage register and its valid bit shift forward one stage; stage 0 loads `in_valid`.
  - When adv=0, all stages hold.
  - `in_ready` = adv, combinational from `out_ready` and `out_valid`.
  - Bubbles travel as valid=0 and do not collapse. Only the final stage's stall is observed.
- **Hold while stalled.** While `out_valid`=1 and `out_ready`=0, `sum`, the flags and `tag_out` are held stable.
- **No reordering.** Results appear in accept order. No operation is dropped or duplicated.

## Timing
- **Latency.** Exactly `LEVELS`+1 cycles from the accept edge to `out_valid`=1 with no stalls. For `WIDTH`=16 this is 5 cycles.
- **Throughput.** One operation per cycle when `out_ready` is held at 1.
- **Reset values.** While `rst_n`=0:
  - All stage valid bits are 0, so `out_valid`=0.
  - `sum`=0, `cout`=0, `ovf`=0, `tag_out`=0 (all datapath registers are cleared).
  - `zero`=1 (it follows from `sum`=0).
  - `in_ready`=1 (because `out_valid`=0).
- **Reset mid-operation.** Asserting reset asynchronously discards all in-flight operations. The first accept after `rst_n` deasserts behaves exactly as from cold reset.
- **Stall plus new request.** `in_valid`=1 with `out_valid`=1 and `out_ready`=0: the request is not accepted (`in_ready`=0). Upstream must hold `a`, `b`, `cin`, `sub` and `tag_in` stable until it is accepted.
- **Simultaneous events.** `out_ready`=1 with a new accept in the same cycle: the output retires and every stage shifts. Throughput is not lost.

## Test plan
- **Wrap-around.** `WIDTH`=16, a=0xFFFF, b=0x0001, cin=0, sub=0 → after 5 cycles: `sum`=0x0000, `cout`=1, `ovf`=0, `zero`=1.
- **Signed overflow and carry-in.**
  - a=0x7FFF, b=0x0000, cin=1 → `sum`=0x8000, `cout`=0, `ovf`=1, `zero`=0.
  - a=0x8000, b=0x8000 → `sum`=0x0000, `cout`=1, `ovf`=1.
- **Subtraction.**
  - a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) → `sum`=0xFFFE, `cout`=0, `ovf`=0.
  - a=0x0007, b=0x0007, sub=1 → `sum`=0, `cout`=1, `zero`=1.
- **Streaming with backpressure.**
  - Stimulus: 64 random back-to-back operations with tags 0..15 cycling; `out_ready` random at 50%; repeat at `WIDTH`=8, 16, 32, 64.
  - Required: every result matches a reference model, tags return in order, there are no gaps when `out_ready`=1, and outputs stay stable while stalled.
- **Reset mid-stream.**
  - Stimulus: accept 3 operations, pull `rst_n` low for 1 cycle at cycle 2.
  - Required: `out_valid` goes to 0 immediately and no stale result appears. A subsequent single operation returns after exactly 5 cycles.

Source files
------------

// File: rtl/prefix_addsub_pipe.sv
// prefix_addsub_pipe: pipelined Kogge-Stone adder/subtractor of any power-of-two
// width. Stage 0 forms bit propagate/generate. Each of the LEVELS prefix
// levels is registered. Sum and flags come combinationally from the last stage.
// A single global advance enable moves the whole pipe, or holds all of it.
module prefix_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int LEVELS = $clog2(WIDTH);

  // Stage k holds the operation after k prefix levels; stage 0 is capture.
  logic [LEVELS:0]                 vld;
  logic [LEVELS:0][WIDTH-1:0]      bp_s;   // bit-level propagate, needed for the final xor
  logic [LEVELS:0][WIDTH-1:0]      gg_s;   // group generate
  logic [LEVELS-1:0][WIDTH-1:0]    gp_s;   // group propagate, not needed after the last level
  logic [LEVELS:0]                 c0_s;
  logic [LEVELS:0]                 am_s;
  logic [LEVELS:0]                 bm_s;
  logic [LEVELS:0][TAG_W-1:0]      tag_s;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0_in;
  logic [WIDTH-1:0] g_fold;
  logic [WIDTH-1:0] carry;

  // Prefix generate step: bit i combines with bit i-d. Bits below d receive zeros
  // from the shift, so they pass through unchanged.
  function automatic logic [WIDTH-1:0] prefix_g(input logic [WIDTH-1:0] g,
                                                input logic [WIDTH-1:0] pg,
                                                input int d);
    return g | (pg & (g << d));
  endfunction

  // Prefix propagate step: the low d bits are forced to pass through via the mask.
  function automatic logic [WIDTH-1:0] prefix_p(input logic [WIDTH-1:0] pg,
                                                input int d);
    return pg & ((pg << d) | ~({WIDTH{1'b1}} << d));
  endfunction

  assign adv      = ~vld[LEVELS] | out_ready;
  assign in_ready = adv;

  assign b_eff = sub ? ~b : b;
  assign c0_in = sub | cin;

  // Carry-in enters here once as part of G_0. It is not added again at the output.
  assign g_fold = {gg_s[0][WIDTH-1:1], gg_s[0][0] | (bp_s[0][0] & c0_s[0])};

  // Whole-pipe shift register. Bubbles advance as vld=0, and a stall holds every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      bp_s  <= '0;
      gg_s  <= '0;
      gp_s  <= '0;
      c0_s  <= '0;
      am_s  <= '0;
      bm_s  <= '0;
      tag_s <= '0;
    end else if (adv) begin
      vld <= {vld[LEVELS-1:0], in_valid};
      // ---- stage 0: capture operands as propagate/generate ----
      bp_s[0]  <= a ^ b_eff;
      gp_s[0]  <= a ^ b_eff;
      gg_s[0]  <= a & b_eff;
      c0_s[0]  <= c0_in;
      am_s[0]  <= a[WIDTH-1];
      bm_s[0]  <= b_eff[WIDTH-1];
      tag_s[0] <= tag_in;
      // ---- stages 1..LEVELS: Kogge-Stone levels, distance 2^(k-1) ----
      gg_s[1] <= prefix_g(g_fold, gp_s[0], 1);
      for (int k = 2; k <= LEVELS; k++)
        gg_s[k] <= prefix_g(gg_s[k-1], gp_s[k-1], 1 << (k - 1));
      for (int k = 1; k < LEVELS; k++)
        gp_s[k] <= prefix_p(gp_s[k-1], 1 << (k - 1));
      for (int k = 1; k <= LEVELS; k++) begin
        bp_s[k]  <= bp_s[k-1];
        c0_s[k]  <= c0_s[k-1];
        am_s[k]  <= am_s[k-1];
        bm_s[k]  <= bm_s[k-1];
        tag_s[k] <= tag_s[k-1];
      end
    end
  end

  // ---- output: c_0 = c0, c_(i+1) = G_i ----
  assign carry     = {gg_s[LEVELS][WIDTH-2:0], c0_s[LEVELS]};
  assign sum       = bp_s[LEVELS] ^ carry;
  assign cout      = gg_s[LEVELS][WIDTH-1];
  // Same as c_W ^ c_(W-1): the operand signs agree but the result sign differs.
  assign ovf       = (am_s[LEVELS] ~^ bm_s[LEVELS]) & (am_s[LEVELS] ^ sum[WIDTH-1]);
  assign zero      = ~|sum;
  assign tag_out   = tag_s[LEVELS];
  assign out_valid = vld[LEVELS];

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Bench for prefix_addsub_pipe at WIDTH=16. It covers directed arithmetic
// vectors, streaming with random backpressure and reset during operation.
module tb_prefix_addsub_pipe;
  localparam int W  = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          zero;
  logic [TW-1:0] tag_out;

  int errors = 0;
  int checks = 0;

  prefix_addsub_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .zero(zero), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model using integer arithmetic on the signed and unsigned values.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mcin, input logic msub,
                                output logic [W-1:0] s, output logic co, output logic ov);
    int sa, sb, ua, ub, ci, r, ur;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ua = int'({16'd0, ma});
    ub = int'({16'd0, mb});
    ci = mcin ? 1 : 0;
    if (msub) begin
      r  = sa - sb;
      ur = ua - ub;
      co = (ua >= ub);
    end else begin
      r  = sa + sb + ci;
      ur = ua + ub + ci;
      co = (ur > 65535);
    end
    s  = ur[15:0];
    ov = (r > 32767) || (r < -32768);
  endfunction

  typedef struct {
    logic [W-1:0] va, vb;
    logic         vcin, vsub;
    logic [W-1:0] es;
    logic         eco, eov, ez;
  } vec_t;

  vec_t vecs[8];

  task automatic run_single(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vcin, input logic vsub, input logic [TW-1:0] vt,
                            input logic [W-1:0] es, input logic eco, input logic eov,
                            input logic ez);
    int lat;
    a = va; b = vb; cin = vcin; sub = vsub; tag_in = vt;
    in_valid = 1'b1; out_ready = 1'b1;
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'd5);
    check({nm, "_sum"},  64'(sum),  64'(es));
    check({nm, "_cout"}, 64'(cout), 64'(eco));
    check({nm, "_ovf"},  64'(ovf),  64'(eov));
    check({nm, "_zero"}, 64'(zero), 64'(ez));
    check({nm, "_tag"},  64'(tag_out), 64'(vt));
  endtask

  task automatic stream(input string nm, input int n, input int rdy_pct);
    logic [W-1:0]  q_s[$];
    logic          q_c[$];
    logic          q_o[$];
    logic [TW-1:0] q_t[$];
    logic [W-1:0]  ms, hs;
    logic          mc, mo, hc, ho, hz, held, pending, seen;
    logic [TW-1:0] ht;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    held = 1'b0; pending = 1'b0; seen = 1'b0;
    hs = '0; hc = 1'b0; ho = 1'b0; hz = 1'b0; ht = '0;
    in_valid = 1'b0;
    while (got < n && cyc < 3000) begin
      out_ready = ($urandom_range(99) < rdy_pct);
      if (!pending && sent < n) begin
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        tag_in = TW'(sent);
        in_valid = 1'b1;
        pending = 1'b1;
      end
      @(negedge clk);
      if (held) begin
        check({nm, "_hold_vld"}, 64'(out_valid), 64'd1);
        check({nm, "_hold_sum"}, 64'(sum), 64'(hs));
        check({nm, "_hold_flags"}, 64'({cout, ovf, zero}), 64'({hc, ho, hz}));
        check({nm, "_hold_tag"}, 64'(tag_out), 64'(ht));
      end
      if (rdy_pct >= 100 && seen)
        check({nm, "_gap"}, 64'(out_valid), 64'd1);
      check({nm, "_in_ready"}, 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (q_s.size() == 0) begin
          check({nm, "_spurious"}, 64'd1, 64'd0);
        end else begin
          ms = q_s.pop_front(); mc = q_c.pop_front(); mo = q_o.pop_front();
          check({nm, "_sum"},  64'(sum),  64'(ms));
          check({nm, "_cout"}, 64'(cout), 64'(mc));
          check({nm, "_ovf"},  64'(ovf),  64'(mo));
          check({nm, "_zero"}, 64'(zero), 64'(ms == '0));
          check({nm, "_tag"},  64'(tag_out), 64'(q_t.pop_front()));
        end
        got++;
        seen = (got < n);
      end
      held = out_valid && !out_ready;
      hs = sum; hc = cout; ho = ovf; hz = zero; ht = tag_out;
      if (in_valid && in_ready) begin
        model(a, b, cin, sub, ms, mc, mo);
        q_s.push_back(ms); q_c.push_back(mc); q_o.push_back(mo);
        q_t.push_back(tag_in);
        sent++;
        pending = 1'b0;
      end
      @(posedge clk); #1;
      if (!pending) in_valid = 1'b0;
      cyc++;
    end
    check({nm, "_count"}, 64'(got), 64'(n));
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag_in = '0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_flags",     64'({cout, ovf, zero}), 64'(3'b001));
    check("rst_tag",       64'(tag_out),   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_single($sformatf("dir%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
                 TW'(i + 5), vecs[i].es, vecs[i].eco, vecs[i].eov, vecs[i].ez);
    @(posedge clk); #1;

    stream("st_bp", 64, 50);
    stream("st_full", 32, 100);
    repeat (8) begin @(posedge clk); #1; end

    // Reset mid-stream: three accepts, then reset for one cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = W'(16'h0100 + i); b = 16'h0001; cin = 1'b0; sub = 1'b0; tag_in = TW'(i + 1);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("mrst_no_stale", 64'(out_valid), 64'd0);
    end
    run_single("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 4'hA, 16'h0100, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset while a result is stalled at the output.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; tag_in = 4'h7;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    check("stall_valid",    64'(out_valid), 64'd1);
    check("stall_in_ready", 64'(in_ready),  64'd0);
    check("stall_sum",      64'(sum),       64'h3333);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd1);
    check("arst_sum",       64'(sum),       64'd0);
    check("arst_zero",      64'(zero),      64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
